sat_bit_tx: RTL

SAT_BIT_TX -- requirements
Module: sat_bit_tx

---
 rtl/sat_bit_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sat_bit_tx.sv
`timescale 1ns/1ps
// sat_bit_tx: framed serial transmitter -- 8-bit sync word, then MSB-first payload.
// Define SAT_TX_PARITY_EN to append an even-parity bit after the payload.
module sat_bit_tx #(
  parameter int         DATA_W    = 8,
  parameter logic [7:0] SYNC_WORD = 8'h7E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              out,
  output logic              out_en,
  output logic              busy,
  output logic              done
);

  localparam int MAX_B = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W = $clog2(MAX_B);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef SAT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_out, w_out_nxt;
  logic              r_out_en, w_out_en_nxt;
  logic              r_done, w_done_nxt;
  logic [2:0]        w_sync_idx;
`ifdef SAT_TX_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  assign w_sync_idx = 3'd7 - r_cnt[2:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_out_nxt    = r_out;
    w_out_en_nxt = 1'b0;
    w_done_nxt   = 1'b0;
`ifdef SAT_TX_PARITY_EN
    w_par_nxt    = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        // A strobe on the load edge is swallowed; the first sync bit waits for the next one.
        if (load) begin
          w_shift_nxt = data_in;
          w_cnt_nxt   = '0;
          w_state_nxt = SYNC;
`ifdef SAT_TX_PARITY_EN
          w_par_nxt   = ^data_in;
`endif
        end else if (clken) begin
          w_out_nxt = 1'b1;
        end
      end
      SYNC: begin
        if (clken) begin
          w_out_nxt    = SYNC_WORD[w_sync_idx];
          w_out_en_nxt = 1'b1;
          if (r_cnt == SYNC_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DATA;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (clken) begin
          w_out_nxt    = r_shift[DATA_W-1];
          w_out_en_nxt = 1'b1;
          w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
          if (r_cnt == DATA_LAST) begin
            w_cnt_nxt = '0;
`ifdef SAT_TX_PARITY_EN
            w_state_nxt = PAR;
`else
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef SAT_TX_PARITY_EN
      PAR: begin
        if (clken) begin
          w_out_nxt    = r_par;
          w_out_en_nxt = 1'b1;
          w_done_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_out    <= 1'b1;
      r_out_en <= 1'b0;
      r_done   <= 1'b0;
`ifdef SAT_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_out    <= w_out_nxt;
      r_out_en <= w_out_en_nxt;
      r_done   <= w_done_nxt;
`ifdef SAT_TX_PARITY_EN
      r_par    <= w_par_nxt;
`endif
    end
  end

  // ready/busy decode straight from state so reset releases them without an edge.
  assign ready  = (r_state == IDLE);
  assign busy   = (r_state != IDLE);
  assign out    = r_out;
  assign out_en = r_out_en;
  assign done   = r_done;

endmodule
